// File: rtl/cpu_bus_cycle_gen.sv
// Bus-strobe and wait-state generator sitting between a TV80-class core and
// the GameBoy memory/IO fabric. Turns one-hot M-cycle/T-state plus access
// qualifiers into registered MREQ_n/IORQ_n/RD_n/WR_n strobes. Inserts a
// programmable number of T2 wait states per address space. Latches read data.
//
// Index mapping follows the core: mcycle[0] is M1, mcycle[2] is M3.
// tstate[1] is T1, tstate[2] is T2 and tstate[3] is T3.
module cpu_bus_cycle_gen #(
    parameter int unsigned DW      = 8,
    parameter int unsigned T2WRITE = 2,
    parameter int unsigned MEM_WS  = 0,
    parameter int unsigned IO_WS   = 1,
    parameter int unsigned WS_W    = 3
) (
    input  logic          CLK_n,
    input  logic          RESET,
    input  logic          CLKEN,
    input  logic          WAIT_n,
    input  logic [6:0]    mcycle,
    input  logic [6:0]    tstate,
    input  logic          write,
    input  logic          no_read,
    input  logic          iorq,
    input  logic          intcycle_n,
    input  logic [DW-1:0] DI,
    output logic          core_wait_n,
    output logic [DW-1:0] di_reg,
    output logic          MREQ_n,
    output logic          IORQ_n,
    output logic          RD_n,
    output logic          WR_n,
    output logic          ws_busy
);

    localparam logic [WS_W-1:0] MemWsL = MEM_WS[WS_W-1:0];
    localparam logic [WS_W-1:0] IoWsL  = IO_WS[WS_W-1:0];

    typedef enum logic [1:0] {StIdle, StCount, StDone} ws_state_e;

    ws_state_e       st_q;
    logic [WS_W-1:0] cnt_q;
    logic            served_q;
    logic            wait_prev_q;
    logic [DW-1:0]   di_q;
    logic            mreq_q, iorq_q, rd_q, wr_q;
    logic            mreq_d, iorq_d, rd_d, wr_d;

    logic            m1, t1, t2, t3;
    logic            int_ack, bus_access, wr_phase;
    logic [WS_W-1:0] ws_load;

    // Only a subset of the one-hot cycle/state bits drive bus activity.
    logic unused_bits;
    assign unused_bits = ^{mcycle[6:3], mcycle[1], tstate[6:4], tstate[0]};

    assign m1 = mcycle[0];
    assign t1 = tstate[1];
    assign t2 = tstate[2];
    assign t3 = tstate[3];

    assign int_ack    = mcycle[2] & ~intcycle_n;
    assign bus_access = ~int_ack & (m1 | write | ~no_read);
    assign ws_load    = iorq ? IoWsL : MemWsL;

    assign ws_busy     = (cnt_q != '0);
    assign core_wait_n = WAIT_n & ~ws_busy;

    assign di_reg = di_q;
    assign MREQ_n = mreq_q;
    assign IORQ_n = iorq_q;
    assign RD_n   = rd_q;
    assign WR_n   = wr_q;

    // Select the T-states in which WR_n is driven low.
    always_comb begin
        wr_phase = t1 | t2;
        if (T2WRITE == 0) begin
            wr_phase = t2;
        end else if (T2WRITE == 1) begin
            wr_phase = t1 | (t2 & ~core_wait_n);
        end
    end

    // Next strobe values; everything idles high unless a qualifier pulls it low.
    always_comb begin
        mreq_d = 1'b1;
        iorq_d = 1'b1;
        rd_d   = 1'b1;
        wr_d   = 1'b1;
        if (m1) begin
            if (t1 || t2) begin
                rd_d   = ~intcycle_n;
                mreq_d = ~intcycle_n;
            end
            if (t3) begin
                mreq_d = 1'b0;  // refresh
            end
        end else if (int_ack) begin
            if (t2) begin
                iorq_d = 1'b0;
            end
        end else begin
            if ((t1 || t2) && !no_read && !write) begin
                rd_d   = 1'b0;
                iorq_d = ~iorq;
                mreq_d = iorq;
            end
            if (write) begin
                if (t1 || t2) begin
                    iorq_d = ~iorq;
                    mreq_d = iorq;
                end
                if (wr_phase) begin
                    wr_d = 1'b0;
                end
            end
        end
    end

    // Strobe registers; updated every edge, independent of CLKEN.
    always_ff @(posedge CLK_n) begin
        if (RESET) begin
            mreq_q <= 1'b1;
            iorq_q <= 1'b1;
            rd_q   <= 1'b1;
            wr_q   <= 1'b1;
        end else begin
            mreq_q <= mreq_d;
            iorq_q <= iorq_d;
            rd_q   <= rd_d;
            wr_q   <= wr_d;
        end
    end

    // Wait-state FSM: load once per T2, count down on CLKEN, rearm after T2.
    always_ff @(posedge CLK_n) begin
        if (RESET) begin
            st_q     <= StIdle;
            cnt_q    <= '0;
            served_q <= 1'b0;
        end else begin
            case (st_q)
                StIdle: begin
                    if (CLKEN && t2 && bus_access && !served_q) begin
                        served_q <= 1'b1;
                        cnt_q    <= ws_load;
                        st_q     <= (ws_load == '0) ? StDone : StCount;
                    end
                end
                StCount: begin
                    if (cnt_q == '0) begin
                        st_q <= StDone;
                    end else if (CLKEN) begin
                        cnt_q <= cnt_q - WS_W'(1);
                        if (cnt_q == WS_W'(1)) begin
                            st_q <= StDone;
                        end
                    end
                end
                StDone: begin
                    if (!t2) begin
                        st_q     <= StIdle;
                        served_q <= 1'b0;
                    end
                end
                default: st_q <= StIdle;
            endcase
        end
    end

    // Read-data latch; a registered low core_wait_n lets the release edge
    // capture data even when CLKEN is not asserted on that edge.
    always_ff @(posedge CLK_n) begin
        if (RESET) begin
            di_q        <= '0;
            wait_prev_q <= 1'b1;
        end else begin
            wait_prev_q <= core_wait_n;
            if (t2 && core_wait_n && !write && !no_read && (CLKEN || !wait_prev_q)) begin
                di_q <= DI;
            end
        end
    end

endmodule

// File: tb/tb_cpu_bus_cycle_gen.sv
// Scoreboard bench for cpu_bus_cycle_gen. Two instances share stimulus:
// dut_a uses T2WRITE=0/MEM_WS=0/IO_WS=2, dut_b uses T2WRITE=2/MEM_WS=1/IO_WS=2.
// Expectations are queued after each clock edge and compared on the next
// falling edge by an independent monitor.
module tb_cpu_bus_cycle_gen;

    localparam logic [6:0] M1 = 7'b0000001;
    localparam logic [6:0] M2 = 7'b0000010;
    localparam logic [6:0] M3 = 7'b0000100;
    localparam logic [6:0] T1 = 7'b0000010;
    localparam logic [6:0] T2 = 7'b0000100;
    localparam logic [6:0] T3 = 7'b0001000;
    localparam logic [6:0] T4 = 7'b0010000;

    logic       CLK_n = 1'b0;
    logic       RESET, CLKEN, WAIT_n, write, no_read, iorq, intcycle_n;
    logic [6:0] mcycle, tstate;
    logic [7:0] DI;

    logic       a_cwn, a_mreq, a_iorq, a_rd, a_wr, a_busy;
    logic       b_cwn, b_mreq, b_iorq, b_rd, b_wr, b_busy;
    logic [7:0] a_di, b_di;

    always #5 CLK_n = ~CLK_n;

    cpu_bus_cycle_gen #(
        .DW(8), .T2WRITE(0), .MEM_WS(0), .IO_WS(2), .WS_W(3)
    ) dut_a (
        .CLK_n(CLK_n), .RESET(RESET), .CLKEN(CLKEN), .WAIT_n(WAIT_n),
        .mcycle(mcycle), .tstate(tstate), .write(write), .no_read(no_read),
        .iorq(iorq), .intcycle_n(intcycle_n), .DI(DI),
        .core_wait_n(a_cwn), .di_reg(a_di), .MREQ_n(a_mreq), .IORQ_n(a_iorq),
        .RD_n(a_rd), .WR_n(a_wr), .ws_busy(a_busy)
    );

    cpu_bus_cycle_gen #(
        .DW(8), .T2WRITE(2), .MEM_WS(1), .IO_WS(2), .WS_W(3)
    ) dut_b (
        .CLK_n(CLK_n), .RESET(RESET), .CLKEN(CLKEN), .WAIT_n(WAIT_n),
        .mcycle(mcycle), .tstate(tstate), .write(write), .no_read(no_read),
        .iorq(iorq), .intcycle_n(intcycle_n), .DI(DI),
        .core_wait_n(b_cwn), .di_reg(b_di), .MREQ_n(b_mreq), .IORQ_n(b_iorq),
        .RD_n(b_rd), .WR_n(b_wr), .ws_busy(b_busy)
    );

    // Observation word: {di, core_wait_n, ws_busy, MREQ_n, IORQ_n, RD_n, WR_n}
    logic [13:0] obs_a, obs_b;
    assign obs_a = {a_di, a_cwn, a_busy, a_mreq, a_iorq, a_rd, a_wr};
    assign obs_b = {b_di, b_cwn, b_busy, b_mreq, b_iorq, b_rd, b_wr};

    typedef struct {
        string       name;
        bit          sel;
        logic [13:0] exp;
        logic [13:0] mask;
    } chk_t;

    chk_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push(input string n, input bit s, input logic [13:0] e, input logic [13:0] m);
        chk_t c;
        c.name = n;
        c.sel  = s;
        c.exp  = e;
        c.mask = m;
        sb.push_back(c);
    endtask

    // Strobe nibble order: {MREQ_n, IORQ_n, RD_n, WR_n}
    task automatic e_stb(input string n, input bit s, input logic [3:0] stb);
        push(n, s, {10'h0, stb}, 14'h000F);
    endtask

    task automatic e_wt(input string n, input bit s, input logic cwn, input logic busy);
        push(n, s, {8'h00, cwn, busy, 4'h0}, 14'h0030);
    endtask

    task automatic e_di(input string n, input bit s, input logic [7:0] d);
        push(n, s, {d, 6'h00}, 14'h3FC0);
    endtask

    // Drive one cycle's inputs just after the falling edge, then take the rising edge.
    task automatic cyc(input logic rst, input logic en, input logic wn, input logic [6:0] m,
                       input logic [6:0] t, input logic wr, input logic nr, input logic io,
                       input logic intn, input logic [7:0] d);
        @(negedge CLK_n);
        #1;
        RESET      = rst;
        CLKEN      = en;
        WAIT_n     = wn;
        mcycle     = m;
        tstate     = t;
        write      = wr;
        no_read    = nr;
        iorq       = io;
        intcycle_n = intn;
        DI         = d;
        @(posedge CLK_n);
    endtask

    // Monitor: compare every queued expectation against the settled outputs.
    initial begin
        chk_t        c;
        logic [13:0] obs;
        forever begin
            @(negedge CLK_n);
            while (sb.size() > 0) begin
                c   = sb.pop_front();
                obs = c.sel ? obs_b : obs_a;
                checks++;
                if ((obs & c.mask) !== (c.exp & c.mask)) begin
                    errors++;
                    $display("FAIL %s dut_%s got %h want %h (mask %h)", c.name,
                             c.sel ? "b" : "a", obs & c.mask, c.exp & c.mask, c.mask);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        RESET = 1'b1; CLKEN = 1'b1; WAIT_n = 1'b1; mcycle = M1; tstate = T2;
        write = 1'b0; no_read = 1'b0; iorq = 1'b0; intcycle_n = 1'b1; DI = 8'hA5;

        // Reset held two clocks while the core sits in M1/T2
        cyc(1, 1, 1, M1, T2, 0, 0, 0, 1, 8'hA5);
        e_stb("rst_stb", 0, 4'hF); e_stb("rst_stb", 1, 4'hF);
        e_di("rst_di", 0, 8'h00);  e_wt("rst_wait", 0, 1, 0);
        cyc(1, 1, 0, M1, T2, 0, 0, 0, 1, 8'hA5);
        e_wt("rst_wait_follow", 0, 0, 0); e_wt("rst_wait_follow", 1, 0, 0);
        e_di("rst_di2", 1, 8'h00);

        // M1 fetch
        cyc(0, 1, 1, M1, T1, 0, 0, 0, 1, 8'hA5);
        e_stb("m1_t1", 0, 4'b0101);
        cyc(0, 1, 1, M1, T2, 0, 0, 0, 1, 8'hA5);
        e_stb("m1_t2", 0, 4'b0101); e_di("m1_di", 0, 8'hA5);
        e_wt("m1_nowait", 0, 1, 0); e_wt("m1_memws1", 1, 0, 1);
        cyc(0, 1, 1, M1, T2, 0, 0, 0, 1, 8'hA5);
        e_wt("m1_nowait2", 0, 1, 0); e_wt("m1_memws1_rel", 1, 1, 0);
        cyc(0, 1, 1, M1, T3, 0, 0, 0, 1, 8'hA5);
        e_stb("m1_refresh", 0, 4'b0111); e_wt("m1_nowait3", 0, 1, 0);
        cyc(0, 1, 1, M1, T4, 0, 0, 0, 1, 8'hA5);
        e_stb("m1_t4", 0, 4'hF);

        // IO read with two wait states
        cyc(0, 1, 1, M2, T1, 0, 0, 1, 1, 8'h00);
        e_stb("io_t1", 0, 4'b1001); e_stb("io_t1", 1, 4'b1001);
        cyc(0, 1, 1, M2, T2, 0, 0, 1, 1, 8'h00);
        e_wt("io_ws_a", 0, 0, 1); e_wt("io_ws_b", 1, 0, 1);
        e_di("io_di_load", 0, 8'h00); e_stb("io_t2", 0, 4'b1001);
        cyc(0, 1, 1, M2, T2, 0, 0, 1, 1, 8'h3C);
        e_wt("io_ws1", 0, 0, 1); e_di("io_di_stall", 0, 8'h00);
        cyc(0, 1, 1, M2, T2, 0, 0, 1, 1, 8'h3C);
        e_wt("io_release", 0, 1, 0); e_wt("io_release", 1, 1, 0);
        e_di("io_di_hold", 0, 8'h00);
        cyc(0, 1, 1, M2, T2, 0, 0, 1, 1, 8'h3C);
        e_di("io_di", 0, 8'h3C); e_di("io_di", 1, 8'h3C);
        cyc(0, 1, 1, M2, T3, 0, 0, 1, 1, 8'h3C);
        e_stb("io_t3", 0, 4'hF);

        // Memory write: T2-only (dut_a) vs T1+T2 (dut_b)
        cyc(0, 1, 1, M2, T1, 1, 0, 0, 1, 8'h3C);
        e_stb("wr_t1", 0, 4'b0111); e_stb("wr_t1", 1, 4'b0110);
        cyc(0, 1, 1, M2, T2, 1, 0, 0, 1, 8'h3C);
        e_stb("wr_t2", 0, 4'b0110); e_stb("wr_t2", 1, 4'b0110);
        e_wt("wr_memws", 1, 0, 1);
        cyc(0, 1, 1, M2, T2, 1, 0, 0, 1, 8'h3C);
        e_stb("wr_t2b", 0, 4'b0110); e_stb("wr_t2b", 1, 4'b0110);
        e_wt("wr_memws_rel", 1, 1, 0); e_di("wr_no_latch", 0, 8'h3C);
        cyc(0, 1, 1, M2, T3, 1, 0, 0, 1, 8'h3C);
        e_stb("wr_t3", 0, 4'hF); e_stb("wr_t3", 1, 4'hF);

        // Interrupt acknowledge
        cyc(0, 1, 1, M3, T1, 0, 0, 0, 0, 8'h3C);
        e_stb("inta_t1", 0, 4'hF);
        cyc(0, 1, 1, M3, T2, 0, 0, 0, 0, 8'h3C);
        e_stb("inta_t2", 0, 4'b1011); e_stb("inta_t2", 1, 4'b1011);
        e_wt("inta_nows", 1, 1, 0);
        cyc(0, 1, 1, M3, T3, 0, 0, 0, 0, 8'h3C);
        e_stb("inta_t3", 0, 4'hF);

        // Memory read, MEM_WS=1, WAIT_n low five clocks with CLKEN mostly low
        cyc(0, 1, 1, M2, T1, 0, 0, 0, 1, 8'h11);
        e_stb("mr_t1", 1, 4'b0101);
        cyc(0, 1, 1, M2, T2, 0, 0, 0, 1, 8'h11);
        e_wt("mr_ws", 1, 0, 1); e_di("mr_di0", 1, 8'h11);
        cyc(0, 0, 0, M2, T2, 0, 0, 0, 1, 8'h5A);
        e_wt("mr_w1", 1, 0, 1); e_wt("mr_w1", 0, 0, 0);
        cyc(0, 1, 0, M2, T2, 0, 0, 0, 1, 8'h5A);
        e_wt("mr_w2_cnt_done", 1, 0, 0); e_di("mr_w2_di", 1, 8'h11);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, M2, T2, 0, 0, 0, 1, 8'h5A);
        e_wt("mr_w5", 1, 0, 0); e_di("mr_w5_di", 0, 8'h11);
        cyc(0, 0, 1, M2, T2, 0, 0, 0, 1, 8'h5A);
        e_di("mr_rise", 1, 8'h5A); e_di("mr_rise", 0, 8'h5A);
        e_wt("mr_rise_wait", 1, 1, 0);
        cyc(0, 0, 1, M2, T2, 0, 0, 0, 1, 8'h77);
        e_di("mr_once", 1, 8'h5A);
        cyc(0, 1, 1, M2, T3, 0, 0, 0, 1, 8'h77);
        e_stb("mr_t3", 1, 4'hF);

        // IO write, reset asserted mid-count
        cyc(0, 1, 1, M2, T1, 1, 0, 1, 1, 8'h77);
        e_stb("rw_t1", 0, 4'b1011); e_stb("rw_t1", 1, 4'b1010);
        cyc(0, 1, 1, M2, T2, 1, 0, 1, 1, 8'h77);
        e_stb("rw_t2", 0, 4'b1010); e_wt("rw_ws", 0, 0, 1); e_wt("rw_ws", 1, 0, 1);
        cyc(1, 1, 1, M2, T2, 1, 0, 1, 1, 8'h77);
        e_stb("rst_mid", 0, 4'hF); e_stb("rst_mid", 1, 4'hF);
        e_wt("rst_mid_cnt", 0, 1, 0); e_wt("rst_mid_cnt", 1, 1, 0);
        e_di("rst_mid_di", 0, 8'h00);
        cyc(0, 1, 1, M2, T4, 0, 0, 0, 1, 8'h77);
        e_stb("post_rst", 1, 4'hF); e_wt("post_rst", 1, 1, 0);

        @(negedge CLK_n);
        #2;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
